// File: rtl/bus_pkg.sv
// Shared types and constants for the shared-RAM bus sequencer.
// BUS_SEQ_SPI_STEAL_EN lets SPI take idle video slots.
package bus_pkg;

  localparam int unsigned SLOTS_PER_FRAME = 8;
  localparam int unsigned SLOT_BITS       = 3;
  localparam int unsigned SLOT_CYCLES     = 8;
  localparam int unsigned CYC_BITS        = 3;
  localparam int unsigned WE_LAST_CYC     = SLOT_CYCLES - 2;

  typedef enum logic [1:0] {
    OWNER_NONE  = 2'd0,
    OWNER_CPU   = 2'd1,
    OWNER_VIDEO = 2'd2,
    OWNER_SPI   = 2'd3
  } owner_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_HOLD   = 2'd2
  } bus_state_t;

  // Slot ownership from slot class and the requests sampled at setup.
  function automatic owner_t decode_owner(input logic is_cpu, input logic is_video,
                                          input logic video_req, input logic spi_req);
    owner_t o;
    o = OWNER_NONE;
    if (is_cpu) begin
      o = OWNER_CPU;
    end else if (is_video) begin
      if (video_req) o = OWNER_VIDEO;
`ifdef BUS_SEQ_SPI_STEAL_EN
      else if (spi_req) o = OWNER_SPI;
`else
      else o = OWNER_NONE;
`endif
    end else if (spi_req) begin
      o = OWNER_SPI;
    end
    return o;
  endfunction

endpackage

// File: rtl/bus_sequencer_if.sv
// Strobe, request/ack and RAM-control bundle of the bus sequencer.
interface bus_sequencer_if;
  import bus_pkg::*;

  logic                 setup_en_i;
  logic                 capture_en_i;
  logic                 cpu_we_i;
  logic                 video_req_i;
  logic                 video_ack_o;
  logic                 spi_req_i;
  logic                 spi_we_i;
  logic                 spi_ack_o;
  logic [1:0]           owner_o;
  logic                 ram_oe_n_o;
  logic                 ram_we_n_o;
  logic                 cpu_be_o;
  logic                 cpu_clk_en_o;
  logic [SLOT_BITS-1:0] slot_o;

  modport master (
    input  setup_en_i, capture_en_i, cpu_we_i, video_req_i, spi_req_i, spi_we_i,
    output video_ack_o, spi_ack_o, owner_o, ram_oe_n_o, ram_we_n_o,
           cpu_be_o, cpu_clk_en_o, slot_o
  );

  modport slave (
    output setup_en_i, capture_en_i, cpu_we_i, video_req_i, spi_req_i, spi_we_i,
    input  video_ack_o, spi_ack_o, owner_o, ram_oe_n_o, ram_we_n_o,
           cpu_be_o, cpu_clk_en_o, slot_o
  );

endinterface

// File: rtl/bus_sequencer.sv
// Shared-RAM slot scheduler: 8 slots per frame, CPU/video/SPI ownership, RAM strobes.
// Define BUS_SEQ_SPI_STEAL_EN to grant unused video slots to SPI.
module bus_sequencer
  import bus_pkg::*;
#(
  parameter int unsigned CPU_SLOT    = 7,
  parameter int unsigned VIDEO_SLOT0 = 0,
  parameter int unsigned VIDEO_SLOT1 = 1
) (
  input  logic            clk_sys_i,
  input  logic            reset_i,
  bus_sequencer_if.master bus
);

  logic                 synced;
  bus_state_t           state;
  owner_t               owner;
  logic [CYC_BITS-1:0]  cyc;
  logic [SLOT_BITS-1:0] slot;
  logic                 ram_oe_n;
  logic                 ram_we_n;
  logic                 cpu_be;
  logic                 cpu_clk_en;
  logic                 video_ack;
  logic                 spi_ack;

  logic                 capture_hit;
  logic [SLOT_BITS-1:0] slot_nxt;
  owner_t               owner_nxt;
  logic                 write_nxt;

  // Capture is applied before setup, so a coincident setup sees the advanced slot.
  always_comb begin
    capture_hit = synced & bus.capture_en_i;
    slot_nxt    = capture_hit ? slot + SLOT_BITS'(1) : slot;
    owner_nxt   = decode_owner(slot_nxt == SLOT_BITS'(CPU_SLOT),
                               (slot_nxt == SLOT_BITS'(VIDEO_SLOT0)) ||
                               (slot_nxt == SLOT_BITS'(VIDEO_SLOT1)),
                               bus.video_req_i, bus.spi_req_i);
    write_nxt   = ((owner_nxt == OWNER_CPU) && bus.cpu_we_i) ||
                  ((owner_nxt == OWNER_SPI) && bus.spi_we_i);
  end

  always_ff @(posedge clk_sys_i or posedge reset_i) begin
    if (reset_i) begin
      synced     <= 1'b0;
      state      <= ST_IDLE;
      owner      <= OWNER_NONE;
      cyc        <= '0;
      slot       <= '0;
      ram_oe_n   <= 1'b1;
      ram_we_n   <= 1'b1;
      cpu_be     <= 1'b0;
      cpu_clk_en <= 1'b0;
      video_ack  <= 1'b0;
      spi_ack    <= 1'b0;
    end else begin
      video_ack  <= 1'b0;
      spi_ack    <= 1'b0;
      cpu_clk_en <= 1'b0;

      if (synced) begin
        case (state)
          ST_ACTIVE: begin
            if (cyc != CYC_BITS'(SLOT_CYCLES - 1)) cyc <= cyc + CYC_BITS'(1);
            // Release WE one cycle early to leave address/data hold before capture.
            if (cyc == CYC_BITS'(WE_LAST_CYC)) ram_we_n <= 1'b1;
            if (bus.capture_en_i) begin
              state      <= ST_HOLD;
              ram_oe_n   <= 1'b1;
              ram_we_n   <= 1'b1;
              video_ack  <= (owner == OWNER_VIDEO);
              spi_ack    <= (owner == OWNER_SPI);
              cpu_clk_en <= (owner == OWNER_CPU);
            end
          end
          ST_HOLD: begin
            state  <= ST_IDLE;
            owner  <= OWNER_NONE;
            cpu_be <= 1'b0;
          end
          default: ;
        endcase
        if (bus.capture_en_i) slot <= slot_nxt;
      end

      // A setup in any state starts a fresh slot; an unfinished access is dropped.
      if (bus.setup_en_i) begin
        synced   <= 1'b1;
        state    <= ST_ACTIVE;
        owner    <= owner_nxt;
        cpu_be   <= (owner_nxt == OWNER_CPU);
        cyc      <= CYC_BITS'(1);
        ram_oe_n <= !((owner_nxt != OWNER_NONE) && !write_nxt);
        ram_we_n <= !((owner_nxt != OWNER_NONE) && write_nxt);
      end
    end
  end

  assign bus.owner_o      = owner;
  assign bus.slot_o       = slot;
  assign bus.ram_oe_n_o   = ram_oe_n;
  assign bus.ram_we_n_o   = ram_we_n;
  assign bus.cpu_be_o     = cpu_be;
  assign bus.cpu_clk_en_o = cpu_clk_en;
  assign bus.video_ack_o  = video_ack;
  assign bus.spi_ack_o    = spi_ack;

endmodule

// File: doc/bus_sequencer.md
Name: bus_sequencer

Overview:
- Consumes the 64 MHz slot strobes (setup_en/capture_en, one pair per 8-cycle slot) and runs the shared-RAM bus schedule.
- Counts 8 slots per 1 µs frame and assigns each slot to CPU, video or SPI.
- Drives the RAM strobes and address-mux select, and generates the 1 MHz CPU clock-enable.
- Sits between the strobe generator and the RAM/CPU/video/SPI datapaths.

Parameters:
- CPU_SLOT, 7, slot index owned by the 6502 every frame.
- VIDEO_SLOT0, 0, first video fetch slot (character).
- VIDEO_SLOT1, 1, second video fetch slot (font).

Ports:
- clk_sys_i  in  1  64 MHz system clock
- reset_i  in  1  asynchronous, active-high reset
- setup_en_i  in  1  one-cycle strobe: first cycle of a slot
- capture_en_i  in  1  one-cycle strobe: last cycle of a slot
- cpu_we_i  in  1  CPU write (inverted RWB), sampled at setup_en_i of CPU slot
- video_req_i  in  1  video fetch wanted in this video slot, sampled at setup_en_i
- video_ack_o  out  1  one-cycle pulse: video data valid on RAM bus
- spi_req_i  in  1  SPI bridge access request (level)
- spi_we_i  in  1  SPI write, sampled with spi_req_i
- spi_ack_o  out  1  one-cycle pulse: SPI access done
- owner_o  out  2  address-mux select: NONE=0, CPU=1, VIDEO=2, SPI=3
- ram_oe_n_o  out  1  RAM output enable, active low
- ram_we_n_o  out  1  RAM write enable, active low
- cpu_be_o  out  1  CPU bus enable, high during CPU slot
- cpu_clk_en_o  out  1  one-cycle pulse per frame: advance CPU
- slot_o  out  3  current slot index

Behaviour:
- Reset (async): owner_o=NONE, ram_oe_n_o=1, ram_we_n_o=1, cpu_be_o=0, cpu_clk_en_o=0, video_ack_o=0, spi_ack_o=0, slot_o=0, synced=0.
- Sync: all strobes are ignored until the first setup_en_i after reset, which sets synced. A capture_en_i arriving while owner is NONE and unsynced is ignored.
- slot_o increments (mod 8, 7→0 wraps) on the cycle after each synced capture_en_i.
- Owner decision, registered at setup_en_i, visible the next cycle:
  - slot==CPU_SLOT → CPU.
  - Video slots → VIDEO if video_req_i, else NONE.
  - Other slots → SPI if spi_req_i, else NONE.
- FSM states: IDLE → ACTIVE (on setup_en_i) → HOLD (cycle after capture_en_i) → IDLE.
  - An unexpected setup_en_i while ACTIVE restarts ACTIVE for the new slot. The in-flight access is abandoned with no ack.
- Read (CPU !cpu_we, VIDEO, SPI !spi_we): ram_oe_n_o=0 from the cycle after setup_en_i through the capture_en_i cycle inclusive.
- Write: ram_we_n_o=0 from the cycle after setup_en_i until the cycle before capture_en_i, giving 1 cycle of data/address hold. ram_oe_n_o stays 1.
- owner_o holds through HOLD, then returns to NONE.
- Acks: video_ack_o / spi_ack_o pulse for 1 cycle, the cycle after capture_en_i of the owning slot. cpu_clk_en_o pulses on the same cycle for the CPU slot.
- cpu_be_o: high exactly while owner==CPU.
- SPI requester holds spi_req_i until spi_ack_o and drops it the cycle after. If req is still high at the next eligible setup_en_i, it counts as a new access.
- Simultaneous setup_en_i and capture_en_i: capture is processed first, then setup.
- Reset mid-slot: strobes are released immediately and no ack is issued.

Optional Feature:
- Macro: BUS_SEQ_SPI_STEAL_EN.
- Defined: a video slot with video_req_i=0 at setup_en_i is granted to SPI if spi_req_i=1.
- Undefined: such slots stay NONE (bus idle).

Decomposition:
- Package bus_pkg holds:
  - owner_t enum (NONE/CPU/VIDEO/SPI).
  - SLOTS_PER_FRAME=8, SLOT_BITS=3.
  - bus_state_t (IDLE/ACTIVE/HOLD).
- No sub-module. A single always_ff FSM plus owner-decode function is natural.

Test Plan:
1. Reset, then strobes every 8 cycles with no requests → only slot 7 active each frame; cpu_clk_en_o pulses once per 64 cycles; ram_oe_n_o low 7 cycles per CPU read slot.
2. cpu_we_i=1 in slot 7 → ram_we_n_o low 6 cycles (setup+1 .. capture-1); ram_oe_n_o stays 1.
3. spi_req_i raised during slot 2 → granted slot 3; spi_ack_o 1 cycle after slot-3 capture; owner_o=3 during slot 3.
4. video_req_i=0 at slot 0 with spi_req_i=1 → with BUS_SEQ_SPI_STEAL_EN, SPI is acked after slot 0; without it, owner stays NONE and SPI is acked after slot 2.
5. reset_i asserted mid-ACTIVE write → ram_we_n_o=1 asynchronously; no spi_ack_o; resync on the next setup_en_i with slot_o=0.
6. capture_en_i before any setup_en_i after reset → ignored; slot_o stays 0; no pulses.
